// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: bound-mode encodings, ONESHOT
// state type and the range clamp used for loaded values.
package counter_pkg;

   localparam int MODE_WRAP     = 32'sd0;
   localparam int MODE_SATURATE = 32'sd1;
   localparam int MODE_ONESHOT  = 32'sd2;
   localparam int MODE_INVALID  = 32'sd3;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_STOPPED = 1'b1
   } oneshot_state_e;

   function automatic logic [31:0] clamp(input logic [31:0] val,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
      logic [31:0] res;
      if (val < lo) begin
         res = lo;
      end else if (val > hi) begin
         res = hi;
      end else begin
         res = val;
      end
      return res;
   endfunction

endpackage

// File: rtl/counter_step_calc.sv
// Combinational next-count and terminal-event detection for one step of
// STEP in either direction, evaluated one bit wider than the count.
module counter_step_calc #(
   parameter int unsigned DATA_WIDTH = 32'd8,
   parameter int unsigned COUNT_FROM = 32'd0,
   parameter int unsigned COUNT_TO   = 32'd10,
   parameter int unsigned STEP       = 32'd1
) (
   input  logic [DATA_WIDTH-1:0] i_cnt,
   input  logic                  i_dir,
   output logic [DATA_WIDTH-1:0] o_next,
   output logic                  o_terminal
);

   localparam logic [DATA_WIDTH:0] C_STEP      = (DATA_WIDTH+1)'(STEP);
   localparam logic [DATA_WIDTH:0] C_TO        = (DATA_WIDTH+1)'(COUNT_TO);
   // Cannot overflow: COUNT_FROM + STEP <= COUNT_TO + 1 <= 2^DATA_WIDTH.
   localparam logic [DATA_WIDTH:0] C_FROM_STEP = (DATA_WIDTH+1)'(COUNT_FROM + STEP);

   logic [DATA_WIDTH:0] w_cnt_ext;
   logic [DATA_WIDTH:0] w_next_full;

   // Step in the selected direction and flag a crossing of the range bound
   always_comb begin
      w_cnt_ext = {1'b0, i_cnt};
      if (i_dir) begin
         w_next_full = w_cnt_ext + C_STEP;
         o_terminal  = (w_next_full > C_TO);
      end else begin
         w_next_full = w_cnt_ext - C_STEP;
         o_terminal  = (w_cnt_ext < C_FROM_STEP);
      end
      o_next = w_next_full[DATA_WIDTH-1:0];
   end

endmodule

// File: rtl/updown_counter.sv
// Up/down range counter with wrap, saturate or one-shot bound handling,
// synchronous load/clear and a registered terminal-count pulse.
module updown_counter #(
   parameter int unsigned DATA_WIDTH = 32'd8,
   parameter int unsigned COUNT_FROM = 32'd0,
   parameter int unsigned COUNT_TO   = 32'd10,
   parameter int unsigned STEP       = 32'd1,
   parameter string       MODE       = "WRAP"
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  dir,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_val,
   input  logic                  clr,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  tc,
   output logic                  done
);

   import counter_pkg::*;

   localparam int MODE_SEL = (MODE == "WRAP")     ? MODE_WRAP :
                             (MODE == "SATURATE") ? MODE_SATURATE :
                             (MODE == "ONESHOT")  ? MODE_ONESHOT : MODE_INVALID;

   localparam logic [DATA_WIDTH-1:0] C_FROM = DATA_WIDTH'(COUNT_FROM);
   localparam logic [DATA_WIDTH-1:0] C_TO   = DATA_WIDTH'(COUNT_TO);

   if (COUNT_FROM > COUNT_TO) begin : g_bad_range
      $fatal(1, "updown_counter: COUNT_FROM must not exceed COUNT_TO");
   end
   if ((DATA_WIDTH < 32'd32) && ((COUNT_TO >> DATA_WIDTH) != 32'd0)) begin : g_bad_width
      $fatal(1, "updown_counter: COUNT_TO does not fit in DATA_WIDTH bits");
   end
   if ((STEP < 32'd1) || (STEP > COUNT_TO - COUNT_FROM + 32'd1)) begin : g_bad_step
      $fatal(1, "updown_counter: STEP outside 1..COUNT_TO-COUNT_FROM+1");
   end
   if (MODE_SEL == MODE_INVALID) begin : g_bad_mode
      $fatal(1, "updown_counter: MODE must be WRAP, SATURATE or ONESHOT");
   end

   logic [DATA_WIDTH-1:0] r_out;
   logic                  r_tc;
   logic                  r_done;
   oneshot_state_e        r_state;

   logic [DATA_WIDTH-1:0] w_next;
   logic                  w_terminal;
   logic [DATA_WIDTH-1:0] w_load_clamped;

   assign w_load_clamped = DATA_WIDTH'(clamp(32'(load_val), COUNT_FROM, COUNT_TO));

   counter_step_calc #(
      .DATA_WIDTH (DATA_WIDTH),
      .COUNT_FROM (COUNT_FROM),
      .COUNT_TO   (COUNT_TO),
      .STEP       (STEP)
   ) u_step (
      .i_cnt      (r_out),
      .i_dir      (dir),
      .o_next     (w_next),
      .o_terminal (w_terminal)
   );

   // Count register, tc pulse and ONESHOT state with priority rst > clr > load > en
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out   <= C_FROM;
         r_tc    <= 1'b0;
         r_done  <= 1'b0;
         r_state <= ST_RUN;
      end else if (clr) begin
         r_out   <= dir ? C_FROM : C_TO;
         r_tc    <= 1'b0;
         r_done  <= 1'b0;
         r_state <= ST_RUN;
      end else if (load) begin
         r_out   <= w_load_clamped;
         r_tc    <= 1'b0;
         r_done  <= 1'b0;
         r_state <= ST_RUN;
      end else if (en && (r_state == ST_RUN)) begin
         if (!w_terminal) begin
            r_out <= w_next;
            r_tc  <= 1'b0;
         end else begin
            r_tc <= 1'b1;
            case (MODE_SEL)
               MODE_WRAP: begin
                  r_out <= dir ? C_FROM : C_TO;
               end
               MODE_SATURATE: begin
                  r_out <= dir ? C_TO : C_FROM;
               end
               MODE_ONESHOT: begin
                  r_out   <= dir ? C_TO : C_FROM;
                  r_done  <= 1'b1;
                  r_state <= ST_STOPPED;
               end
               default: begin
                  r_out <= r_out;
               end
            endcase
         end
      end else begin
         r_tc <= 1'b0;
      end
   end

   assign out  = r_out;
   assign tc   = r_tc;
   assign done = r_done;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: WRAP (STEP 1 and 3), SATURATE and
// ONESHOT instances share stimulus; each phase checks one of them.
module tb_updown_counter;

   logic       clk = 1'b0;
   logic       rst, en, dir, load, clr;
   logic [7:0] load_val;

   logic [7:0] out_w, out_s3, out_sat, out_one;
   logic       tc_w, tc_s3, tc_sat, tc_one;
   logic       done_w, done_s3, done_sat, done_one;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   updown_counter u_wrap (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
      .clr(clr), .out(out_w), .tc(tc_w), .done(done_w));

   updown_counter #(.STEP(3)) u_step3 (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
      .clr(clr), .out(out_s3), .tc(tc_s3), .done(done_s3));

   updown_counter #(.MODE("SATURATE")) u_sat (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
      .clr(clr), .out(out_sat), .tc(tc_sat), .done(done_sat));

   updown_counter #(.MODE("ONESHOT")) u_one (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
      .clr(clr), .out(out_one), .tc(tc_one), .done(done_one));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0; clr = 1'b0; load_val = 8'd0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   int s3_out [9] = '{3, 6, 9, 0, 10, 7, 4, 1, 10};
   int s3_tc  [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 1};

   initial begin
      // Reset state
      do_reset();
      chk("reset_out", out_w, 0);
      chk("reset_tc", tc_w, 0);
      chk("reset_done", done_w, 0);
      chk("reset_done_oneshot", done_one, 0);
      chk("reset_out_oneshot", out_one, 0);

      // Default WRAP, up: 1..10, 0 with tc, then 1
      en = 1'b1; dir = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("wrap_out", out_w, k % 11);
         chk("wrap_tc", tc_w, (k == 11) ? 1 : 0);
      end

      // STEP=3 WRAP: up across the top, then down across the bottom
      do_reset();
      en = 1'b1;
      for (int k = 0; k < 9; k++) begin
         dir = (k < 4) ? 1'b1 : 1'b0;
         tick();
         chk("step3_out", out_s3, s3_out[k]);
         chk("step3_tc", tc_s3, s3_tc[k]);
      end

      // SATURATE: hold at 10 pulsing tc, then step back down
      do_reset();
      en = 1'b1; dir = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         tick();
         chk("sat_out", out_sat, (k <= 10) ? k : 10);
         chk("sat_tc", tc_sat, (k > 10) ? 1 : 0);
      end
      dir = 1'b0;
      tick();
      chk("sat_down_out", out_sat, 9);
      chk("sat_down_tc", tc_sat, 0);

      // ONESHOT: stop at 10, ignore en, resume after load
      do_reset();
      en = 1'b1; dir = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk("one_out", out_one, (k <= 10) ? k : 10);
         chk("one_tc", tc_one, (k == 11) ? 1 : 0);
         chk("one_done", done_one, (k >= 11) ? 1 : 0);
      end
      load = 1'b1; load_val = 8'd4;
      tick();
      chk("one_load_out", out_one, 4);
      chk("one_load_done", done_one, 0);
      chk("one_load_tc", tc_one, 0);
      load = 1'b0;
      for (int k = 5; k <= 10; k++) begin
         tick();
         chk("one_resume_out", out_one, k);
      end
      tick();
      chk("one_restop_tc", tc_one, 1);
      chk("one_restop_done", done_one, 1);
      // Asynchronous reset in the middle of the tc pulse
      rst = 1'b1;
      #2;
      chk("one_async_out", out_one, 0);
      chk("one_async_tc", tc_one, 0);
      chk("one_async_done", done_one, 0);
      rst = 1'b0;

      // Priority and clamp
      do_reset();
      en = 1'b1; load = 1'b1; load_val = 8'd200;
      tick();
      chk("load_clamp_out", out_w, 10);
      chk("load_clamp_tc", tc_w, 0);
      chk("load_clamp_step3", out_s3, 10);
      clr = 1'b1; load_val = 8'd5; dir = 1'b1;
      tick();
      chk("clr_over_load", out_w, 0);
      load = 1'b0; dir = 1'b0;
      tick();
      chk("clr_down_start", out_w, 10);
      chk("clr_down_tc", tc_w, 0);
      clr = 1'b0;

      // Asynchronous reset mid-count
      do_reset();
      en = 1'b1; dir = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
      end
      chk("pre_reset_out", out_w, 7);
      rst = 1'b1;
      #2;
      chk("async_out", out_w, 0);
      chk("async_tc", tc_w, 0);
      chk("async_done", done_one, 0);
      #2;
      rst = 1'b0;
      tick();
      chk("post_reset_first", out_w, 1);
      chk("post_reset_tc", tc_w, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
